// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
// The master side is the operand source and result consumer; the slave side is the adder.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock through a registered carry,
// with valid/ready on both sides, carry-out and signed-overflow flags.
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic              clk,
  input logic              rst_n,
  seq_chunk_adder_if.slave bus
);
  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  generate
    if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("seq_chunk_adder: WIDTH must be >= 1 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic             ready_en_q, ready_en_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic             in_ready_c;
  logic             out_valid_c;
  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] sum_shift;
  logic [WIDTH-1:0] opa_shift;
  logic [WIDTH-1:0] opb_shift;

  // The low chunk of the operand registers is always the one being added; operands shift
  // down and the result shifts in from the top, so after NCH steps sum is fully aligned.
  assign chunk_res = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]} + (CHUNK+1)'(c_q);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
      if (gi == NCH - 1) begin : g_top
        assign sum_shift[gi*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
        assign opa_shift[gi*CHUNK +: CHUNK] = '0;
        assign opb_shift[gi*CHUNK +: CHUNK] = '0;
      end else begin : g_low
        assign sum_shift[gi*CHUNK +: CHUNK] = sum_q[(gi+1)*CHUNK +: CHUNK];
        assign opa_shift[gi*CHUNK +: CHUNK] = opa_q[(gi+1)*CHUNK +: CHUNK];
        assign opb_shift[gi*CHUNK +: CHUNK] = opb_q[(gi+1)*CHUNK +: CHUNK];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      sum_q      <= '0;
      c_q        <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= ready_en_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      sum_q      <= sum_d;
      c_q        <= c_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ready_en_d = 1'b1;
    opa_d      = opa_q;
    opb_d      = opb_q;
    sum_d      = sum_q;
    c_d        = c_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    idx_d      = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_c) begin
          // Subtraction is a + ~b + ~borrow, so invert b and the incoming carry up front.
          opa_d   = bus.a;
          opb_d   = bus.sub ? ~bus.b : bus.b;
          c_d     = bus.sub ^ bus.cin;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d = sum_shift;
        opa_d = opa_shift;
        opb_d = opb_shift;
        c_d   = chunk_res[CHUNK];
        idx_d = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = chunk_res[CHUNK];
          // a^b^s at the MSB is the carry into it; XOR with the carry out gives overflow.
          ovf_d   = opa_q[CHUNK-1] ^ opb_q[CHUNK-1] ^ chunk_res[CHUNK-1] ^ chunk_res[CHUNK];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = (state_q == IDLE) && ready_en_q;
    out_valid_c = (state_q == DONE);
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule
